// File: rtl/fifo_uart_tx_if.sv
// Bundle of FIFO-side and serial-side signals for the FIFO-draining UART transmitter.
`timescale 1ns/1ps
interface fifo_uart_tx_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_dout;
  logic             fifo_rd;
  logic             txd;
  logic             busy;
  logic             done;

  // master: the transmitter itself; slave: the FIFO / line environment around it
  modport master (
    input  fifo_empty, fifo_dout,
    output fifo_rd, txd, busy, done
  );
  modport slave (
    output fifo_empty, fifo_dout,
    input  fifo_rd, txd, busy, done
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops a show-ahead FIFO and sends back-to-back frames:
// start bit, WIDTH data bits LSB first, optional parity, one or two stop bits.
`timescale 1ns/1ps
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 234,
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned PARITY       = 0,  // 0 none, 1 odd, 2 even
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic           clk,
  input  logic           reset,
  fifo_uart_tx_if.master bus
);
  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {StIdle, StStart, StData, StPar, StStop} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  shift_q, shift_d, shift_nxt;
  logic              par_q, par_d;
  logic              stop_q, stop_d;
  logic              txd_q, txd_d;
  logic              bit_end, last_stop, load;

  assign bit_end   = (cnt_q == CntW'(CLKS_PER_BIT - 1));
  assign last_stop = (state_q == StStop) && (stop_q == 1'(STOP_BITS - 1)) && bit_end;
  // Reload either from idle or in the final cycle of a frame, so frames abut
  assign load      = !reset && !bus.fifo_empty && ((state_q == StIdle) || last_stop);
  assign shift_nxt = shift_q >> 1;

  assign bus.fifo_rd = load;
  assign bus.txd     = txd_q;
  assign bus.busy    = (state_q != StIdle);
  assign bus.done    = last_stop;

  // Next-state logic: txd_d is the level of the bit that starts on the next edge
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    stop_d  = stop_q;
    txd_d   = txd_q;
    if (load) begin
      state_d = StStart;
      cnt_d   = '0;
      idx_d   = '0;
      shift_d = bus.fifo_dout;
      par_d   = 1'b0;
      stop_d  = 1'b0;
      txd_d   = 1'b0;
    end else if (state_q != StIdle) begin
      if (!bit_end) begin
        cnt_d = cnt_q + CntW'(1);
      end else begin
        cnt_d = '0;
        case (state_q)
          StStart: begin
            state_d = StData;
            idx_d   = '0;
            txd_d   = shift_q[0];
          end
          StData: begin
            // par_d accumulates the XOR of all data bits sent so far
            par_d   = par_q ^ shift_q[0];
            shift_d = shift_nxt;
            if (idx_q == IdxW'(WIDTH - 1)) begin
              if (PARITY != 0) begin
                state_d = StPar;
                txd_d   = (par_q ^ shift_q[0]) ^ (PARITY == 1);
              end else begin
                state_d = StStop;
                stop_d  = 1'b0;
                txd_d   = 1'b1;
              end
            end else begin
              idx_d = idx_q + IdxW'(1);
              txd_d = shift_nxt[0];
            end
          end
          StPar: begin
            state_d = StStop;
            stop_d  = 1'b0;
            txd_d   = 1'b1;
          end
          StStop: begin
            if (stop_q == 1'(STOP_BITS - 1)) begin
              state_d = StIdle;
            end else begin
              stop_d = stop_q + 1'b1;
            end
            txd_d = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // State register with synchronous reset back to an idle-high line
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      stop_q  <= 1'b0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      stop_q  <= stop_d;
      txd_q   <= txd_d;
    end
  end
endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Serial transmit stage that drains a show-ahead FIFO and emits each element as an asynchronous serial frame on a single line. It sits directly downstream of the team's synchronous FIFO and consumes its `dout`/`empty` outputs, popping with `rd`. Each frame is: start bit, data LSB-first, optional parity, then one or two stop bits. Frames are sent back-to-back with no idle gap while the FIFO is non-empty.

## Interface
Parameters:
- `CLKS_PER_BIT`, 234 — clock cycles per serial bit; must be ≥ 2 (234 gives 115200 baud at 27 MHz).
- `WIDTH`, 8 — data bits per frame; matches the FIFO element width.
- `PARITY`, 0 — parity mode: 0 none, 1 odd, 2 even.
- `STOP_BITS`, 1 — stop bits per frame: 1 or 2.

Ports:
- `clk`  input  1  — single clock; all state changes on the rising edge.
- `reset`  input  1  — synchronous, active-high; returns the block to idle.
- `fifo_empty`  input  1  — FIFO empty flag.
- `fifo_dout`  input  WIDTH  — FIFO head element, valid whenever `fifo_empty`=0.
- `fifo_rd`  output  1  — pop request to the FIFO; one-cycle pulse per frame.
- `txd`  output  1  — serial line; idle high; registered.
- `busy`  output  1  — high while a frame is in progress.
- `done`  output  1  — one-cycle pulse in the last cycle of each frame's final stop bit.

## Operation
- States: IDLE, START, DATA, PAR, STOP.
- Registers: bit-cycle counter (width clog2(CLKS_PER_BIT)), bit index, shift register (WIDTH), parity accumulator, stop-bit index.
- Load condition `L` = !reset && !fifo_empty && (state==IDLE || last cycle of the final stop bit).
  - `fifo_rd` = `L` (combinational).
  - On the edge where `L`=1: shift register ← `fifo_dout`; state ← START; counter ← 0; `txd` ← 0.
- Each bit is held for exactly CLKS_PER_BIT cycles. When the counter reaches CLKS_PER_BIT-1, it clears and the block advances to the next bit.
- State transitions:
  - START → DATA.
  - DATA: transmits bit 0 first and shifts right; after WIDTH bits, goes to PAR if PARITY≠0, otherwise to STOP.
  - PAR: odd mode makes the total count of ones in data plus parity odd; even mode makes it even.
  - STOP: `txd`=1 for STOP_BITS bit periods. At the end, goes to START if `L`, otherwise to IDLE.
- `busy` = (state≠IDLE). `done` is asserted when state==STOP, the final stop bit is active, and the counter is at CLKS_PER_BIT-1.
- Reset values: state IDLE, `txd`=1, `busy`=0, `done`=0, `fifo_rd`=0, all counters 0.
  - Reset mid-frame abandons the frame: `txd` returns to 1 on the next edge.
  - No pop occurs while `reset` is high.
- `fifo_rd` is never asserted when `fifo_empty`=1, and never more than once per frame.
- Invalid parameter values (PARITY=3, STOP_BITS∉{1,2}) are unsupported and need not be checked.

## Timing
- Latency: if `fifo_empty` falls at cycle t in IDLE, `fifo_rd` is high in cycle t and the start bit appears on `txd` from cycle t+1.
- Frame length: (1 + WIDTH + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles.
- Back-to-back frames:
  - The next pop coincides with the `done` cycle.
  - The next start bit begins on the following cycle, with zero idle cycles between frames.
- `busy` rises on the cycle after the pop. It falls on the cycle after `done` only if no reload occurred.
- The data byte is captured at pop time. Later changes on `fifo_dout` do not affect the frame in flight.

## Test plan
- Reset: hold `reset`=1 with `fifo_empty`=0 for 5 cycles → `txd`=1, `busy`=0, `done`=0, `fifo_rd`=0 on every cycle.
- Single frame, CLKS_PER_BIT=4, no parity, 1 stop, data 0xA5 →
  - exactly one `fifo_rd` pulse;
  - `txd` carries bits 0,1,0,1,0,0,1,0,1,1, each held 4 cycles;
  - `busy` high for 40 cycles; `done` pulses in cycle 40.
- Back-to-back 0x00 then 0xFF, FIFO kept non-empty → second `fifo_rd` coincides with the first `done`; 80 contiguous frame cycles with no idle-high gap between the stop bit and the second start bit.
- Parity, data 0x07 →
  - PARITY=2 (even): parity bit 1;
  - PARITY=1 (odd): parity bit 0;
  - each frame is 44 cycles at CLKS_PER_BIT=4.
- Reset mid-frame: assert `reset` for 1 cycle at frame cycle 13 →
  - `txd`=1 and `busy`=0 on the next cycle;
  - no extra `fifo_rd`;
  - the following frame of 0x3C is transmitted intact.
- STOP_BITS=2, data 0x81, then FIFO empty → stop high for 8 cycles; `done` in frame cycle 44; block returns to IDLE; `fifo_rd` stays 0 while empty.
